// File: rtl/matrix_3x3_ctrl.sv
// rtl/matrix_3x3_ctrl.sv - pixel-stream sequencer for the 3x3 window generator
//
// Purpose: gates the raw pixel stream into the window generator, tracks the
// column/row of each accepted pixel and flags the cycles on which the 3x3
// window holds a complete in-image neighbourhood, with its centre coordinates.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   frame_start  one-cycle pulse before the first pixel of a frame
//   pix_de       pixel valid
//   pix_data     pixel value
//   mat_clken    clock enable to the window generator (combinational)
//   mat_data     data input to the window generator (= pix_data)
//   win_valid    window is a full in-image neighbourhood this cycle
//   win_x/win_y  centre (p22) coordinates, valid with win_valid
//   frame_done   pulse alongside the final valid window of a frame
//   frame_err    pulse when frame_start truncates an incomplete frame
//   busy         high while a frame is being accepted
module matrix_3x3_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = 10,
  parameter int YW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          pix_de,
  input  logic [7:0]    pix_data,
  output logic          mat_clken,
  output logic [7:0]    mat_data,
  output logic          win_valid,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic          frame_done,
  output logic          frame_err,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [XW-1:0] LAST_COL = XW'(IMG_W - 1);
  localparam logic [YW-1:0] LAST_ROW = YW'(IMG_H - 1);

  state_t        state_q, state_d;
  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic [XW-1:0] win_x_q, win_x_d;
  logic [YW-1:0] win_y_q, win_y_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic          accept;

  // A pixel arriving together with frame_start belongs to no frame and is dropped.
  assign accept    = pix_de & (state_q == ST_ACTIVE) & ~frame_start;
  assign mat_clken = accept;
  assign mat_data  = pix_data;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = 1'b0;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      ST_ACTIVE: begin
        if (accept) begin
          // The pixel just shifted into p33 puts (col-1,row-1) at p22 next cycle.
          // Columns/rows 0 and 1 are masked: those windows straddle a line wrap
          // or still hold shift-RAM contents from the previous frame.
          if (col_q >= XW'(2) && row_q >= YW'(2)) begin
            win_valid_d = 1'b1;
            win_x_d     = col_q - XW'(1);
            win_y_d     = row_q - YW'(1);
          end
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d        = '0;
              state_d      = ST_DONE;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + YW'(1);
            end
          end else begin
            col_d = col_q + XW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // frame_start overrides everything, from any state.
    if (frame_start) begin
      state_d     = ST_ACTIVE;
      col_d       = '0;
      row_d       = '0;
      frame_err_d = (state_q == ST_ACTIVE) && ((col_q != '0) || (row_q != '0));
    end

    busy_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: doc/matrix_3x3_ctrl.md
Name: matrix_3x3_ctrl

Overview:
- Sequencer for the 3x3 window generator: accepts the raw 8-bit pixel stream and drives the window generator's clock-enable and data input.
- Tracks column and row position inside the frame.
- Flags the cycles on which the 3x3 window holds a fully valid neighbourhood, with the centre-pixel coordinates alongside.
- Sits between the camera/pattern source and the matrix_3X3 + filter stage in each image-processing pipeline.

Parameters:
- IMG_W, 640, active pixels per line; must equal the shift-RAM tap length of the window generator.
- IMG_H, 480, active lines per frame.
- XW, 10, column counter / coordinate width; must satisfy 2^XW >= IMG_W.
- YW, 10, row counter / coordinate width; must satisfy 2^YW >= IMG_H.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- frame_start, input, 1, one-cycle pulse before the first pixel of a frame.
- pix_de, input, 1, pixel valid.
- pix_data, input, 8, pixel value.
- mat_clken, output, 1, clken to the window generator (combinational).
- mat_data, output, 8, data_in to the window generator (combinational, = pix_data).
- win_valid, output, 1, window p11..p33 is a full in-image neighbourhood this cycle.
- win_x, output, XW, centre (p22) column, valid with win_valid.
- win_y, output, YW, centre (p22) row, valid with win_valid.
- frame_done, output, 1, one-cycle pulse after the last pixel of the frame is accepted.
- frame_err, output, 1, one-cycle pulse when frame_start truncates an incomplete frame.
- busy, output, 1, high in ACTIVE.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; col=0, row=0.
  - win_valid=0, win_x=0, win_y=0, frame_done=0, frame_err=0, busy=0.
  - mat_clken=0 (combinational from state).
- States:
  - IDLE: waits for frame_start.
  - ACTIVE: pixels accepted.
  - DONE: one cycle, then IDLE.
- frame_start, any state, has highest priority:
  - Next state ACTIVE; col=0, row=0.
  - If current state is ACTIVE and (col!=0 or row!=0), frame_err pulses next cycle.
  - A pix_de in the same cycle as frame_start is ignored: mat_clken=0.
- Accept rule: accept = pix_de & (state==ACTIVE) & ~frame_start. mat_clken = accept; mat_data = pix_data always.
- Gaps with pix_de low inside a line are legal. Counters hold, window generator is not clocked.
- Counters on accept:
  - If col==IMG_W-1: col<=0, row<=row+1. Otherwise col<=col+1.
  - On the last pixel (col==IMG_W-1, row==IMG_H-1): next state DONE, counters cleared to 0.
- In DONE and IDLE, pix_de is ignored (mat_clken=0). DONE->IDLE unconditionally after one cycle unless frame_start.
- Window alignment: accepting pixel (c,r) shifts it into p33 on that clock edge. Next cycle p22 holds pixel (c-1,r-1).
- win_valid is registered, high the cycle after an accept with c>=2 and r>=2. Registered with it: win_x=c-1, win_y=r-1. Otherwise win_valid=0 and win_x/win_y hold their last value.
- Latency: 1 clk from accept to win_valid.
- Valid windows per frame: exactly (IMG_W-2)*(IMG_H-2). Border centres (x=0, x=IMG_W-1, y=0, y=IMG_H-1) never flagged.
- Wrap across a line boundary:
  - col 0 and col 1 accepts never raise win_valid; this masks windows straddling two lines.
  - Row 0 and row 1 never raise win_valid; this masks stale shift-RAM contents from the previous frame.
- frame_done is registered, pulses in the same cycle as the final win_valid (centre IMG_W-2, IMG_H-2).
- busy = (state==ACTIVE), registered.

Test Plan:
- Reset mid-frame: IMG_W=4, IMG_H=3; accept 5 pixels, pulse rst_n low -> all outputs 0 immediately. Pixels ignored until next frame_start.
- Full frame, no gaps: IMG_W=4, IMG_H=3; frame_start, 12 pixels 1..12 on consecutive cycles.
  - win_valid exactly twice, at (1,1) then (2,1).
  - p22=6 then 7; p11..p33 = {1,2,3,5,6,7,9,10,11}, then shifted by one column.
  - frame_done coincides with the second win_valid; then IDLE.
- Gapped input: same frame with pix_de low for 3 cycles after every pixel -> identical window values/coordinates; mat_clken high only on 12 cycles; counters frozen during gaps.
- Truncated frame: frame_start, 6 pixels, frame_start -> frame_err pulses once; counters restart at (0,0); following complete frame yields 2 valid windows and frame_done.
- Ignored data: pix_de high in IDLE, in DONE and in the frame_start cycle -> mat_clken stays 0; no counter change.
- Default size: IMG_W=640, IMG_H=480 frame -> 638*478=304964 win_valid pulses; first at (1,1), last at (638,478); frame_done once.
